// File: rtl/ps2_mouse_defs.sv
// PS/2 mouse packet layout shared by the assembler and its bench.
// States, byte slots and header bit positions of the 3-byte packet.
package ps2_mouse_defs;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } ps2_state_e;

  localparam int B0_IDX    = 0;
  localparam int B1_IDX    = 1;
  localparam int B2_IDX    = 2;
  localparam int PKT_BYTES = 3;

  localparam int SYNC_BIT   = 3;
  localparam int X_SIGN_BIT = 4;
  localparam int Y_SIGN_BIT = 5;
  localparam int X_OVF_BIT  = 6;
  localparam int Y_OVF_BIT  = 7;

  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic [8:0] y;
    logic [8:0] x;
    logic [2:0] buttons;
  } ps2_pkt_t;

  function automatic ps2_pkt_t ps2_decode(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    ps2_pkt_t p;
    p.buttons = b0[2:0];
    p.x       = {b0[X_SIGN_BIT], b1};
    p.y       = {b0[Y_SIGN_BIT], b2};
    p.x_ovf   = b0[X_OVF_BIT];
    p.y_ovf   = b0[Y_OVF_BIT];
    return p;
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles, flags the last allowed one.
// Saturates at the limit so a stalled clear can never wrap it.
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == LIMIT);
  assign expired  = enable & at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_packet_assembler.sv
// Collects three PS/2 mouse bytes into one movement/button packet.
// Bad bytes or an inter-byte timeout discard the partial packet.
module ps2_packet_assembler
  import ps2_mouse_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_error,
  output logic [8:0] x_axis,
  output logic [8:0] y_axis,
  output logic [2:0] buttons,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       package_done,
  output logic       packet_error
);

  ps2_state_e state, next_state;
  ps2_pkt_t   pkt_q;
  logic [7:0] b0_q, b1_q;
  logic       good, bad;
  logic       expired, timeout;
  logic       done_d, err_d;
  logic       cnt_clear, cnt_en;

  assign good    = byte_valid & ~byte_error;
  assign bad     = byte_valid & byte_error;
  assign timeout = expired & ~byte_valid;

  always_comb begin
    next_state = state;
    done_d     = 1'b0;
    unique case (state)
      WAIT_B0: begin
        if (good && byte_data[SYNC_BIT]) next_state = WAIT_B1;
      end
      WAIT_B1: begin
        if (bad || timeout) next_state = WAIT_B0;
        else if (good)      next_state = WAIT_B2;
      end
      WAIT_B2: begin
        if (bad || timeout) begin
          next_state = WAIT_B0;
        end else if (good) begin
          next_state = WAIT_B0;
          done_d     = b0_q[SYNC_BIT];
        end
      end
      default: next_state = WAIT_B0;
    endcase
    // timeout is already gated to WAIT_B1/WAIT_B2 by cnt_en
    err_d = bad | timeout;
  end

  assign cnt_clear = byte_valid | (next_state == WAIT_B0);
  assign cnt_en    = (state != WAIT_B0);

  ps2_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WAIT_B0;
      b0_q         <= '0;
      b1_q         <= '0;
      pkt_q        <= '0;
      package_done <= 1'b0;
      packet_error <= 1'b0;
    end else begin
      state        <= next_state;
      package_done <= done_d;
      packet_error <= err_d;
      if (state == WAIT_B0 && next_state == WAIT_B1) begin
        b0_q <= byte_data;
      end
      if (state == WAIT_B1 && next_state == WAIT_B2) begin
        b1_q <= byte_data;
      end
      if (done_d) begin
        pkt_q <= ps2_decode(b0_q, b1_q, byte_data);
      end
    end
  end

  assign x_axis  = pkt_q.x;
  assign y_axis  = pkt_q.y;
  assign buttons = pkt_q.buttons;
  assign x_ovf   = pkt_q.x_ovf;
  assign y_ovf   = pkt_q.y_ovf;

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: vector table, corner sequences and
// random traffic against a queue-based packet model.
module tb_ps2_packet_assembler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_error = 1'b0;
  logic [8:0] x_axis, y_axis;
  logic [2:0] buttons;
  logic       x_ovf, y_ovf;
  logic       package_done, packet_error;

  int n_chk  = 0;
  int n_fail = 0;

  ps2_packet_assembler #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_error  (byte_error),
    .x_axis      (x_axis),
    .y_axis      (y_axis),
    .buttons     (buttons),
    .x_ovf       (x_ovf),
    .y_ovf       (y_ovf),
    .package_done(package_done),
    .packet_error(packet_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       done;
    logic       perr;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] b;
    logic       xo;
    logic       yo;
  } vec_t;

  vec_t tbl[21];

  // values of the last completed packet, for hand sequences
  logic [8:0] hx, hy;
  logic [2:0] hb;
  logic       hxo, hyo;

  // reference model state
  logic [7:0] pkt[$];
  logic [8:0] mx, my;
  logic [2:0] mb;
  logic       mxo, myo;
  int         now, last;

  function automatic vec_t mk(
    input logic v, input logic [7:0] d, input logic e,
    input logic dn, input logic pe,
    input logic [8:0] x, input logic [8:0] y,
    input logic [2:0] b, input logic xo, input logic yo
  );
    vec_t r;
    r.v = v; r.d = d; r.e = e; r.done = dn; r.perr = pe;
    r.x = x; r.y = y; r.b = b; r.xo = xo; r.yo = yo;
    return r;
  endfunction

  task automatic chk(
    input string name, input logic dn, input logic pe,
    input logic [8:0] x, input logic [8:0] y,
    input logic [2:0] b, input logic xo, input logic yo
  );
    n_chk++;
    if ({package_done, packet_error, x_axis, y_axis,
         buttons, x_ovf, y_ovf} !== {dn, pe, x, y, b, xo, yo}) begin
      n_fail++;
      $display("FAIL %s: got done=%b err=%b x=%h y=%h btn=%b xo=%b yo=%b, want done=%b err=%b x=%h y=%h btn=%b xo=%b yo=%b",
               name, package_done, packet_error, x_axis, y_axis,
               buttons, x_ovf, y_ovf, dn, pe, x, y, b, xo, yo);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic e);
    byte_valid = v;
    byte_data  = d;
    byte_error = e;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_error = 1'b0;
  endtask

  task automatic hold_chk(input string name, input logic pe);
    chk(name, 1'b0, pe, hx, hy, hb, hxo, hyo);
  endtask

  task automatic rstep(input logic v, input logic [7:0] d, input logic e);
    logic ed, ee;
    ed = 1'b0;
    ee = 1'b0;
    if (v) begin
      if (e) begin
        ee = 1'b1;
        pkt.delete();
      end else if (pkt.size() == 0) begin
        if (d[3]) pkt.push_back(d);
      end else begin
        pkt.push_back(d);
        if (pkt.size() == 3) begin
          mx  = {pkt[0][4], pkt[1]};
          my  = {pkt[0][5], pkt[2]};
          mb  = pkt[0][2:0];
          mxo = pkt[0][6];
          myo = pkt[0][7];
          ed  = 1'b1;
          pkt.delete();
        end
      end
      last = now;
    end else if (pkt.size() != 0 && now - last >= TO) begin
      ee = 1'b1;
      pkt.delete();
    end
    now++;
    cyc(v, d, e);
    chk("random", ed, ee, mx, my, mb, mxo, myo);
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    int         gap;

    tbl[0]  = mk(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 3'b000, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 3'b000, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 8'hFB, 1'b0, 1'b1, 1'b0, 9'h005, 9'h0FB, 3'b001, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h005, 9'h0FB, 3'b001, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 9'h005, 9'h0FB, 3'b001, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 9'h005, 9'h0FB, 3'b001, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 9'h1F0, 9'h110, 3'b000, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h1F0, 9'h110, 3'b000, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 9'h1F0, 9'h110, 3'b000, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 9'h1F0, 9'h110, 3'b000, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 9'h1F0, 9'h110, 3'b000, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 8'hC8, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 9'h001, 9'h002, 3'b000, 1'b0, 1'b0);
    tbl[20] = mk(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 9'h07F, 9'h080, 3'b000, 1'b1, 1'b1);

    #12;
    chk("reset", 1'b0, 1'b0, 9'h000, 9'h000, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].e);
      chk($sformatf("vec%0d", i), tbl[i].done, tbl[i].perr,
          tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].xo, tbl[i].yo);
    end
    hx = 9'h07F; hy = 9'h080; hb = 3'b000; hxo = 1'b1; hyo = 1'b1;

    // 20-cycle gap after byte 0: error exactly 16 cycles later
    cyc(1'b1, 8'h08, 1'b0);
    hold_chk("to_b0", 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      hold_chk($sformatf("to_gap%0d", k), k == TO);
    end
    cyc(1'b1, 8'h01, 1'b0);
    hold_chk("to_late1", 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    hold_chk("to_late2", 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    hold_chk("to_after", 1'b0);

    // byte arriving on the last allowed cycle is accepted
    cyc(1'b1, 8'h08, 1'b0);
    for (int k = 1; k < TO; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      hold_chk($sformatf("edge_gap%0d", k), 1'b0);
    end
    cyc(1'b1, 8'h03, 1'b0);
    hold_chk("edge_b1", 1'b0);
    cyc(1'b1, 8'h04, 1'b0);
    chk("edge_done", 1'b1, 1'b0, 9'h003, 9'h004, 3'b000, 1'b0, 1'b0);

    // asynchronous reset while waiting for byte 2
    cyc(1'b1, 8'h09, 1'b0);
    cyc(1'b1, 8'h05, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid", 1'b0, 1'b0, 9'h000, 9'h000, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("rst_quiet", 1'b0, 1'b0, 9'h000, 9'h000, 3'b000, 1'b0, 1'b0);
    end
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b1, 8'h06, 1'b0);
    chk("rst_first", 1'b1, 1'b0, 9'h007, 9'h006, 3'b000, 1'b0, 1'b0);

    mx = 9'h007; my = 9'h006; mb = 3'b000; mxo = 1'b0; myo = 1'b0;
    now = 0;
    last = 0;
    for (int n = 0; n < 300; n++) begin
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20)
                                         : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) rstep(1'b0, 8'h00, 1'b0);
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 7) d[3] = 1'b1;
      e = ($urandom_range(0, 15) == 0);
      rstep(1'b1, d, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
